// File: rtl/bcd_counter_7seg_mux.sv
// Up/down BCD counter with prescaled tick, checked load and a
// multiplexed, leading-zero-blanking seven-segment driver.
module bcd_counter_7seg_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int MODULUS        = 1000,
  parameter int TICK_CYCLES    = 100_000_000,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic                    clk_100Mhz,
  input  logic                    reset_out,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    blank_lz,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic                    load_err,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_CYCLES);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Elaboration-time only: turns the modulus into BCD constants.
  function automatic logic [W+3:0] to_bcd(input longint v);
    logic [W+3:0] r;
    longint       t;
    r = '0;
    t = v;
    for (int i = 0; i <= NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  localparam logic [W+3:0] MOD_BCD = to_bcd(longint'(MODULUS));
  localparam logic [W+3:0] MAX_BCD = to_bcd(longint'(MODULUS - 1));

  logic [PW-1:0] presc;
  logic          tick;
  logic          load_ok;
  logic          at_top;
  logic          at_zero;
  logic [W-1:0]  inc_val;
  logic [W-1:0]  dec_val;

  assign tick    = enable && (presc == PW'(TICK_CYCLES - 1));
  assign at_top  = (count_bcd == MAX_BCD[W-1:0]);
  assign at_zero = (count_bcd == '0);

  // Valid BCD compares numerically as a plain unsigned vector.
  always_comb begin
    load_ok = ({4'd0, load_value} < MOD_BCD);
    for (int i = 0; i < NUM_DIGITS; i++)
      if (load_value[4*i +: 4] > 4'd9) load_ok = 1'b0;
  end

  always_comb begin
    logic c;
    logic b;
    inc_val = count_bcd;
    dec_val = count_bcd;
    c = 1'b1;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (count_bcd[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
      if (b) begin
        if (count_bcd[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_100Mhz or posedge reset_out) begin
    if (reset_out) begin
      presc     <= '0;
      count_bcd <= '0;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (enable) presc <= tick ? '0 : presc + 1'b1;
      if (load) begin
        if (load_ok) begin
          count_bcd <= load_value;
          presc     <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick) begin
        if (up_down) begin
          count_bcd <= at_top ? '0 : inc_val;
          wrap      <= at_top;
        end else begin
          count_bcd <= at_zero ? MAX_BCD[W-1:0] : dec_val;
          wrap      <= at_zero;
        end
      end
    end
  end

  logic [RW-1:0]         refresh;
  logic [SW-1:0]         sel;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [3:0]            cur_digit;
  logic                  cur_blank;

  // A digit blanks only when it and every digit above it are zero.
  always_comb begin
    logic zero;
    zero = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero = zero && (count_bcd[4*i +: 4] == 4'd0);
      blank_mask[i] = blank_lz && zero && (i != 0);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel == SW'(i)) begin
        cur_digit = count_bcd[4*i +: 4];
        cur_blank = blank_mask[i];
      end
    end
  end

  always_ff @(posedge clk_100Mhz or posedge reset_out) begin
    if (reset_out) begin
      refresh <= '0;
      sel     <= '0;
      anode   <= ~NUM_DIGITS'(1);
      seg     <= 7'b0000001;
    end else begin
      if (refresh == RW'(REFRESH_CYCLES - 1)) begin
        refresh <= '0;
        sel     <= (sel == SW'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
      end else begin
        refresh <= refresh + 1'b1;
      end
      anode <= ~(NUM_DIGITS'(1) << sel);
      seg   <= cur_blank ? 7'b1111111 : enc(cur_digit);
    end
  end

endmodule

// File: doc/bcd_counter_7seg_mux.md
BCD_COUNTER_7SEG_MUX -- requirements
Module: bcd_counter_7seg_mux

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of BCD digits and anodes (legal 1..8).
REQ-002 The block SHALL have parameter MODULUS, default 1000, count modulus (legal 2..10^NUM_DIGITS).
REQ-003 The block SHALL have parameter TICK_CYCLES, default 100_000_000, clk_100Mhz cycles per count tick (legal >=2).
REQ-004 The block SHALL have parameter REFRESH_CYCLES, default 100_000, clk_100Mhz cycles per displayed digit (legal >=2).
REQ-005 The block SHALL have port clk_100Mhz, input, 1 bit, the 100 MHz clock.
REQ-006 The block SHALL have port reset_out, input, 1 bit, reset (asynchronous, active-high).
REQ-007 The block SHALL have port enable, input, 1 bit; 1 = count, 0 = pause.
REQ-008 The block SHALL have port up_down, input, 1 bit; 1 = count up, 0 = count down.
REQ-009 The block SHALL have port load, input, 1 bit, synchronous load strobe.
REQ-010 The block SHALL have port load_value, input, 4*NUM_DIGITS bits, BCD value to load (digit 0 in bits [3:0]).
REQ-011 The block SHALL have port blank_lz, input, 1 bit; 1 = blank leading zeros.
REQ-012 The block SHALL have port count_bcd, output, 4*NUM_DIGITS bits, current count in BCD (registered).
REQ-013 The block SHALL have port wrap, output, 1 bit, one-cycle pulse on modulus wrap.
REQ-014 The block SHALL have port load_err, output, 1 bit, one-cycle pulse on a rejected load.
REQ-015 The block SHALL have port anode, output, NUM_DIGITS bits, active-low digit enables.
REQ-016 The block SHALL have port seg, output, 7 bits, active-low cathodes; seg[6]=a … seg[0]=g.

Function
REQ-017 The prescaler SHALL count 0..TICK_CYCLES-1 only while enable=1, wrap to 0, and hold its value while enable=0.
REQ-018 tick SHALL be high for exactly one cycle when the prescaler equals TICK_CYCLES-1 and enable=1.
REQ-019 On tick with up_down=1, count SHALL advance by 1; from MODULUS-1 it SHALL go to 0 with wrap=1 in the same cycle count_bcd updates.
REQ-020 On tick with up_down=0, count SHALL decrement by 1; from 0 it SHALL go to MODULUS-1 with wrap=1.
REQ-021 The count SHALL be held in per-digit BCD with digit carry/borrow; binary divide/modulo of the count SHALL NOT be used.
REQ-022 load=1 SHALL take priority over tick: count_bcd <= load_value next cycle, no wrap pulse, prescaler reset to 0.
REQ-023 If load_value has any digit >9 or value >= MODULUS, the load SHALL be rejected: count unchanged, load_err=1 for one cycle, prescaler unaffected.
REQ-024 A change in up_down SHALL take effect on the next tick; no glitch or skipped count.
REQ-025 The refresh counter SHALL count 0..REFRESH_CYCLES-1 continuously, independent of enable; on its terminal value, digit select SHALL advance (NUM_DIGITS-1 -> 0).
REQ-026 anode SHALL drive exactly one bit low (selected digit) and all others high, registered.
REQ-027 seg SHALL encode the selected digit: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-028 When blank_lz=1, digit i>0 SHALL show seg=1111111 if digits i..NUM_DIGITS-1 are all 0; digit 0 SHALL never be blanked.
REQ-029 seg and anode SHALL change in the same clock edge (no ghosting between digits).

Reset
REQ-030 When reset_out=1, asynchronously: count_bcd=0, prescaler=0, refresh counter=0, digit select=0, wrap=0, load_err=0.
REQ-031 During reset, anode SHALL be {all 1s except bit0=0} and seg SHALL be 0000001.
REQ-032 Reset asserted mid-tick or mid-load SHALL abort the operation; the first tick after release SHALL occur TICK_CYCLES enabled cycles later.

Verification (NUM_DIGITS=4, TICK_CYCLES=4, REFRESH_CYCLES=2 unless stated)
REQ-033 MODULUS=1000, up, enable=1 from reset -> count_bcd 0x0001 after 4 cycles; 0x0999 -> 0x0000 with wrap pulse.
REQ-034 MODULUS=60, down, starting at 0 -> next tick count_bcd=0x0059, wrap=1 for one cycle.
REQ-035 load_value=0x0123 with load=1 coincident with tick -> count_bcd=0x0123, no wrap; load_value=0x01A3 or 0x1000 -> load_err pulse, count unchanged.
REQ-036 enable=0 for 10 cycles mid-prescale -> count frozen, digit scan continues; resume -> tick after the remaining cycles.
REQ-037 count 0x0007, blank_lz=1 -> digits 3..1 seg=1111111, digit 0 seg=0001111; anode cycles 1110,1101,1011,0111 every 2 cycles.
REQ-038 reset_out pulsed asynchronously between clock edges -> all outputs take reset values immediately.
